// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and helpers for the sequence-detector serial front end.
// Holds the serializer FSM state type, the idle line level and even_parity().
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  function automatic logic even_parity(
    input logic [63:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/seq_bit_serializer_divider.sv
// Bit-period divider: counts 0..DIV-1 while enabled, else holds 0.
// Ports: clk, rst_n (async low), en_i; tick_o (last clock), first_o (first clock).
module seq_bit_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o,
  output logic first_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV==1 MAX is 0, so the counter never leaves 0.
  always_comb begin
    cnt_d = '0;
    if (en_i && cnt_q != MAX)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o  = (cnt_q == MAX);
  assign first_o = (cnt_q == '0);

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words out MSB-first, DIV clks/bit.
// Ports: clk, reset (async low), in_data/in_valid/in_ready, ser_out,
// bit_strobe, busy, done. Macro SEQ_SER_PARITY_EN appends an even-parity bit.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BW = $clog2(NBITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bc_q, bc_d;
  logic             tick, first;
  logic             last, accept;

`ifdef SEQ_SER_PARITY_EN
  logic             par_q, par_d;
`endif

  seq_bit_divider #(
    .DIV (DIV)
  ) u_div (
    .clk     (clk),
    .rst_n   (reset),
    .en_i    (busy),
    .tick_o  (tick),
    .first_o (first)
  );

  assign busy       = (state_q == SHIFT);
  assign last       = busy && tick && (bc_q == LAST_BIT);
  assign in_ready   = !busy || last;
  assign accept     = in_valid && in_ready;
  assign done       = last;
  assign bit_strobe = busy && first;

`ifdef SEQ_SER_PARITY_EN
  // Once all data bits are out, the slot after bit[0] carries parity.
  assign ser_out = !busy ? IDLE_LEVEL :
                   (bc_q == BW'(WIDTH)) ? par_q : sh_q[WIDTH-1];
`else
  assign ser_out = busy ? sh_q[WIDTH-1] : IDLE_LEVEL;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bc_d    = bc_q;
`ifdef SEQ_SER_PARITY_EN
    par_d   = par_q;
`endif
    if (accept) begin
      // Covers both idle accept and zero-gap reload on the last tick.
      state_d = SHIFT;
      sh_d    = in_data;
      bc_d    = '0;
`ifdef SEQ_SER_PARITY_EN
      par_d   = even_parity(64'(in_data));
`endif
    end else if (busy && tick) begin
      if (last) begin
        state_d = IDLE;
        sh_d    = '0;
        bc_d    = '0;
      end else begin
        sh_d = {sh_q[WIDTH-2:0], 1'b0};
        bc_d = bc_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bc_q    <= bc_d;
    end
  end

`ifdef SEQ_SER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: DIV=1 and DIV=3 instances against a
// queue-of-expected-clocks model; directed words then random traffic.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       v   [2];
  logic [7:0] d   [2];
  logic       rdy [2];
  logic       ser [2];
  logic       stb [2];
  logic       bsy [2];
  logic       dn  [2];

  int n_cmp;
  int n_err;

  // Each entry is one expected clock: {ser_out, bit_strobe, done}.
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  seq_bit_serializer #(.WIDTH(8), .DIV(1)) u0 (
    .clk(clk), .reset(rst_n), .in_data(d[0]), .in_valid(v[0]),
    .in_ready(rdy[0]), .ser_out(ser[0]), .bit_strobe(stb[0]),
    .busy(bsy[0]), .done(dn[0])
  );

  seq_bit_serializer #(.WIDTH(8), .DIV(3)) u1 (
    .clk(clk), .reset(rst_n), .in_data(d[1]), .in_valid(v[1]),
    .in_ready(rdy[1]), .ser_out(ser[1]), .bit_strobe(stb[1]),
    .busy(bsy[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [2:0] qhead(input int k);
    if (qsize(k) == 0) return 3'b000;
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic push_word(input int k, input logic [7:0] w);
    int dv;
    logic bt;
    logic [2:0] e;
    dv = (k == 0) ? 1 : 3;
    for (int b = 0; b < NB; b++) begin
      bt = (b < 8) ? w[7-b] : ^w;
      for (int c = 0; c < dv; c++) begin
        e = {bt, (c == 0), (b == NB - 1 && c == dv - 1)};
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  task automatic check_k(input int k);
    logic [2:0] h;
    h = qhead(k);
    chk($sformatf("ser%0d", k), 32'(ser[k]), 32'(h[2]));
    chk($sformatf("stb%0d", k), 32'(stb[k]), 32'(h[1]));
    chk($sformatf("done%0d", k), 32'(dn[k]), 32'(h[0]));
    chk($sformatf("busy%0d", k), 32'(bsy[k]), 32'(qsize(k) != 0));
    chk($sformatf("rdy%0d", k), 32'(rdy[k]), 32'(qsize(k) <= 1));
  endtask

  task automatic cyc(input logic v0, input logic [7:0] d0,
                     input logic v1, input logic [7:0] d1);
    logic acc;
    @(negedge clk);
    check_k(0);
    check_k(1);
    v[0] = v0; d[0] = d0;
    v[1] = v1; d[1] = d1;
    for (int k = 0; k < 2; k++) begin
      acc = v[k] && (qsize(k) <= 1);
      if (qsize(k) != 0) begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      if (acc) push_word(k, d[k]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ser%0d", tag, k), 32'(ser[k]), 32'd0);
      chk($sformatf("%s_rdy%0d", tag, k), 32'(rdy[k]), 32'd1);
      chk($sformatf("%s_stb%0d", tag, k), 32'(stb[k]), 32'd0);
      chk($sformatf("%s_bsy%0d", tag, k), 32'(bsy[k]), 32'd0);
      chk($sformatf("%s_dn%0d", tag, k), 32'(dn[k]), 32'd0);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    v[0] = 1'b0; v[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    q0.delete();
    q1.delete();
    @(negedge clk);
    check_reset_vals("hold");
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    v[0] = 1'b0; v[1] = 1'b0;
    d[0] = 8'h00; d[1] = 8'h00;
    @(negedge clk);
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);

    cyc(1'b1, 8'hA5, 1'b1, 8'h81);
    for (int i = 0; i < 30; i++) cyc(1'b0, 8'h3C, 1'b0, 8'h00);

    cyc(1'b1, 8'hF0, 1'b0, 8'h00);
    for (int i = 0; i < NB; i++) cyc(1'b1, 8'h0F, 1'b0, 8'h00);
    for (int i = 0; i < NB + 3; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);

    cyc(1'b1, 8'h07, 1'b1, 8'h03);
    for (int i = 0; i < 3 * NB + 2; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);

    cyc(1'b1, 8'hFF, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);
    mid_reset();
    cyc(1'b1, 8'h01, 1'b1, 8'h01);
    for (int i = 0; i < 3 * NB + 2; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);

    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 7), 8'($urandom),
          ($urandom_range(0, 9) < 7), 8'($urandom));
    for (int i = 0; i < 3 * NB + 2; i++) cyc(1'b0, 8'h00, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
